// File: rtl/usb_app_pkg.sv
// Shared constants and FSM encoding for the application-side register bridge.
// Command and response bytes match the host tool's ASCII framing.
package usb_app_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h3F;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StGetAddr = 3'd1,
      StGetData = 3'd2,
      StWrite   = 3'd3,
      StRead    = 3'd4,
      StCapture = 3'd5,
      StResp    = 3'd6
   } state_e;

endpackage

// File: rtl/app_timeout_cnt.sv
// Inter-byte timeout counter: expire_o asserts once TIMEOUT_CYCLES byte-less cycles
// have elapsed while enabled. TIMEOUT_CYCLES of 0 disables it entirely.
module app_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 1200
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic enable_i,
   input  logic clear_i,
   output logic expire_o
);

   if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expire_o = 1'b0;
   end else begin : g_cnt
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (!enable_i || clear_i) begin
            cnt_d = '0;
         end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign expire_o = enable_i && (cnt_q == LAST);
   end

endmodule

// File: rtl/app_reg_bridge.sv
// Parses 'W' addr data / 'R' addr byte frames from the OUT stream into register bus
// strobes and returns one response byte per command on the IN stream.
module app_reg_bridge
   import usb_app_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1200,
   parameter int unsigned CNT_WIDTH      = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [7:0]            app_out_data_i,
   input  logic                  app_out_valid_i,
   output logic                  app_out_ready_o,
   output logic [7:0]            app_in_data_o,
   output logic                  app_in_valid_o,
   input  logic                  app_in_ready_i,
   output logic [ADDR_WIDTH-1:0] reg_addr_o,
   output logic [7:0]            reg_wdata_o,
   output logic                  reg_we_o,
   output logic                  reg_re_o,
   input  logic [7:0]            reg_rdata_i,
   output logic                  busy_o,
   output logic [CNT_WIDTH-1:0]  err_cnt_o
);

   state_e                state_q, state_d;
   logic                  wr_q;
   logic                  out_ready_q;
   logic                  in_valid_q;
   logic                  we_q, re_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            wdata_q;
   logic [7:0]            rsp_q;
   logic [CNT_WIDTH-1:0]  err_q;
   logic                  accept;
   logic                  expire;
   logic                  err_inc;
   logic                  is_cmd;

   assign accept = app_out_valid_i & out_ready_q;
   assign is_cmd = (app_out_data_i == CMD_WRITE) || (app_out_data_i == CMD_READ);

   app_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .enable_i((state_q == StGetAddr) || (state_q == StGetData)),
      .clear_i (accept),
      .expire_o(expire)
   );

   // An accepted byte always takes priority over an expiring timeout.
   always_comb begin
      state_d = state_q;
      err_inc = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (is_cmd) begin
                  state_d = StGetAddr;
               end else begin
                  state_d = StResp;
                  err_inc = 1'b1;
               end
            end
         end
         StGetAddr: begin
            if (accept) begin
               state_d = wr_q ? StGetData : StRead;
            end else if (expire) begin
               state_d = StIdle;
               err_inc = 1'b1;
            end
         end
         StGetData: begin
            if (accept) begin
               state_d = StWrite;
            end else if (expire) begin
               state_d = StIdle;
               err_inc = 1'b1;
            end
         end
         StWrite:   state_d = StResp;
         StRead:    state_d = StCapture;
         StCapture: state_d = StResp;
         StResp: begin
            if (app_in_ready_i) begin
               state_d = StIdle;
            end
         end
         default:   state_d = StIdle;
      endcase
   end

   // Handshake outputs are decoded from state_d so they line up with the new state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         wr_q        <= 1'b0;
         out_ready_q <= 1'b0;
         in_valid_q  <= 1'b0;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_q       <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_ready_q <= (state_d == StIdle) || (state_d == StGetAddr) || (state_d == StGetData);
         in_valid_q  <= (state_d == StResp);
         we_q        <= (state_d == StWrite);
         re_q        <= (state_d == StRead);
         if (state_q == StIdle && accept) begin
            wr_q <= (app_out_data_i == CMD_WRITE);
         end
         if (state_q == StGetAddr && accept) begin
            addr_q <= app_out_data_i[ADDR_WIDTH-1:0];
         end
         if (state_q == StGetData && accept) begin
            wdata_q <= app_out_data_i;
         end
         if (state_q == StIdle && accept && !is_cmd) begin
            rsp_q <= RSP_ERR;
         end else if (state_q == StWrite) begin
            rsp_q <= RSP_ACK;
         end else if (state_q == StCapture) begin
            rsp_q <= reg_rdata_i;
         end
         if (err_inc && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
         end
      end
   end

   assign app_out_ready_o = out_ready_q;
   assign app_in_data_o   = rsp_q;
   assign app_in_valid_o  = in_valid_q;
   assign reg_addr_o      = addr_q;
   assign reg_wdata_o     = wdata_q;
   assign reg_we_o        = we_q;
   assign reg_re_o        = re_q;
   assign busy_o          = (state_q != StIdle);
   assign err_cnt_o       = err_q;

endmodule
